alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
//
// PURPOSE
//   Sequences the combinational ALU (alu) for the core. Accepts one operation
//   request at a time over a valid/ready handshake and drives alu_control,
//   alu_AI, alu_BI and alu_carry_in. Registers alu_Y, alu_carry_out and
//   alu_overflow, and returns the result and NZCV flags over a valid/ready
//   response channel. Handles multi-pass ops: 16-bit add for effective
//   address and index math, and SUB/CMP built from ADD with inverted B.
//
// PARAMETERS
//   DATA_W       8  ALU pass width; must equal ALU width (only 8 supported)
//   IDLE_ZERO    1  1: drive ALU operands/carry to 0 outside EXEC states
//
// PORTS
//   clk            in   1        core clock
//   resetn         in   1        async reset, active low
//   req_valid      in   1        request present
//   req_ready      out  1        sequencer can accept (high only in IDLE)
//   req_op         in   3        0 ADD8, 1 SUB8, 2 AND, 3 OR, 4 XOR, 5 SR, 6 ADD16, 7 CMP
//   req_a          in   16       operand A ([7:0] for 8-bit ops)
//   req_b          in   16       operand B ([7:0] for 8-bit ops)
//   req_carry_in   in   1        carry in (ADD8/SUB8/SR/ADD16); ignored by CMP
//   rsp_valid      out  1        result valid; held until rsp_ready
//   rsp_ready      in   1        consumer accepts result
//   rsp_result     out  16       result; [15:8]=0 for 8-bit ops, 0 for CMP
//   rsp_flags      out  4        {N,Z,C,V}
//   rsp_flag_mask  out  4        {N,Z,C,V} update enables for the status reg
//   alu_control    out  3        ALU op code (ADD/AND/OR/XOR/SR from params.vh)
//   alu_AI         out  8        ALU operand A
//   alu_BI         out  8        ALU operand B
//   alu_carry_in   out  1        ALU carry in
//   alu_Y          in   8        ALU result
//   alu_carry_out  in   1        ALU carry out
//   alu_overflow   in   1        ALU signed overflow
//
// BEHAVIOUR
//   States: IDLE -> EXEC_LO -> (EXEC_HI if ADD16) -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid, register op/operands/carry -> EXEC_LO.
//   EXEC_LO: drive the ALU with low bytes; register alu_Y into result[7:0],
//     carry, overflow. ADD16 -> EXEC_HI, else -> RESP.
//   EXEC_HI: drive high bytes, carry_in = registered low-pass carry_out;
//     register result[15:8], carry, overflow -> RESP.
//   RESP: rsp_valid=1, outputs stable; rsp_ready -> IDLE. No new request is
//     accepted in the same cycle (req_ready=0 until IDLE).
//   Latency: 8-bit op accepted at edge T gives rsp_valid after edge T+2;
//     ADD16 after T+3.
//   Op mapping: SUB8 = ADD, BI=~b, cin=req_carry_in (6502 borrow sense);
//     CMP = ADD, BI=~b, cin=1. SR passes req_carry_in (shifted into bit 7).
//   Flags: N = final-pass alu_Y[7]. Z = all result bits zero (both bytes
//     for ADD16). C = final-pass alu_carry_out. V = final-pass alu_overflow.
//   Mask: ADD8/SUB8 1111; CMP 1110; AND/OR/XOR 1100; SR 1110; ADD16 0010.
//   Outside EXEC states: alu_control=ADD. Operands/carry=0 if IDLE_ZERO,
//     else the last driven values.
//   Reset (async, any state, mid-op included): state=IDLE, rsp_valid=0,
//     rsp_result=0, rsp_flags=0, rsp_flag_mask=0, alu_AI/BI/carry=0,
//     alu_control=ADD. Any in-flight op is dropped.
//   Unknown state encodings return to IDLE.
//
// TESTING
//   ADD8 a=0x50,b=0x50,cin=0 -> result 0x00A0, flags N1 Z0 C0 V1, mask 1111,
//     rsp_valid 2 cycles after accept.
//   ADD16 a=0x12FF,b=0x0001,cin=0 -> EXEC_HI sees alu_carry_in=1;
//     result 0x1300, C0, mask 0010, rsp_valid 3 cycles after accept.
//   CMP a=0x10,b=0x10 -> result 0x0000, Z1 C1 N0, mask 1110.
//   CMP a=0x0F,b=0x10 -> C0 N1.
//   SR a=0x03,cin=1 -> result 0x81, C1, mask 1110.
//   XOR a=0xFF,b=0xFF -> result 0, Z1.
//   Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_* stable, req_ready=0,
//     second req_valid not accepted; rsp_ready=1 -> IDLE next cycle, then
//     accept.
//   Assert resetn low during EXEC_HI of an ADD16: all outputs reach reset
//     values immediately (no clock). After release, the next ADD8 completes
//     normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences an external 8-bit combinational ALU for the core. It takes one request at a time,
// runs one pass (or two for ADD16), and returns the registered result, NZCV flags and update mask.
module alu_op_sequencer #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          IDLE_ZERO = 1'b1,
    parameter logic [2:0]  ALU_ADD   = 3'd0,
    parameter logic [2:0]  ALU_OR    = 3'd1,
    parameter logic [2:0]  ALU_XOR   = 3'd2,
    parameter logic [2:0]  ALU_AND   = 3'd3,
    parameter logic [2:0]  ALU_SR    = 3'd4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic                  req_carry_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_result,
    output logic [3:0]            rsp_flags,
    output logic [3:0]            rsp_flag_mask,
    output logic [2:0]            alu_control,
    output logic [DATA_W-1:0]     alu_AI,
    output logic [DATA_W-1:0]     alu_BI,
    output logic                  alu_carry_in,
    input  logic [DATA_W-1:0]     alu_Y,
    input  logic                  alu_carry_out,
    input  logic                  alu_overflow
);

    localparam int unsigned WIDE_W = 2 * DATA_W;

    localparam logic [2:0] OP_ADD8  = 3'd0;
    localparam logic [2:0] OP_SUB8  = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SR    = 3'd5;
    localparam logic [2:0] OP_ADD16 = 3'd6;
    localparam logic [2:0] OP_CMP   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_op, w_op_nxt;
    logic [DATA_W-1:0]   r_a_hi, w_a_hi_nxt;
    logic [DATA_W-1:0]   r_b_hi, w_b_hi_nxt;
    logic [DATA_W-1:0]   r_res_lo, w_res_lo_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDE_W-1:0]   r_rsp_result, w_rsp_result_nxt;
    logic [3:0]          r_rsp_flags, w_rsp_flags_nxt;
    logic [3:0]          r_rsp_mask, w_rsp_mask_nxt;
    logic [2:0]          r_alu_control, w_alu_control_nxt;
    logic [DATA_W-1:0]   r_alu_ai, w_alu_ai_nxt;
    logic [DATA_W-1:0]   r_alu_bi, w_alu_bi_nxt;
    logic                r_alu_cin, w_alu_cin_nxt;
    logic                w_y_zero;
    logic                w_invert_b;

    assign w_y_zero   = (alu_Y == '0);
    assign w_invert_b = (req_op == OP_SUB8) || (req_op == OP_CMP);

    // State and all output registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_op          <= OP_ADD8;
            r_a_hi        <= '0;
            r_b_hi        <= '0;
            r_res_lo      <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_mask    <= '0;
            r_alu_control <= ALU_ADD;
            r_alu_ai      <= '0;
            r_alu_bi      <= '0;
            r_alu_cin     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_a_hi        <= w_a_hi_nxt;
            r_b_hi        <= w_b_hi_nxt;
            r_res_lo      <= w_res_lo_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_result  <= w_rsp_result_nxt;
            r_rsp_flags   <= w_rsp_flags_nxt;
            r_rsp_mask    <= w_rsp_mask_nxt;
            r_alu_control <= w_alu_control_nxt;
            r_alu_ai      <= w_alu_ai_nxt;
            r_alu_bi      <= w_alu_bi_nxt;
            r_alu_cin     <= w_alu_cin_nxt;
        end
    end

    // ALU drives are preloaded one edge ahead so each EXEC state sees its operands directly.
    always_comb begin
        w_state_nxt       = r_state;
        w_op_nxt          = r_op;
        w_a_hi_nxt        = r_a_hi;
        w_b_hi_nxt        = r_b_hi;
        w_res_lo_nxt      = r_res_lo;
        w_req_ready_nxt   = 1'b0;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_result_nxt  = r_rsp_result;
        w_rsp_flags_nxt   = r_rsp_flags;
        w_rsp_mask_nxt    = r_rsp_mask;
        w_alu_control_nxt = ALU_ADD;
        w_alu_ai_nxt      = IDLE_ZERO ? '0 : r_alu_ai;
        w_alu_bi_nxt      = IDLE_ZERO ? '0 : r_alu_bi;
        w_alu_cin_nxt     = IDLE_ZERO ? 1'b0 : r_alu_cin;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid) begin
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = S_EXEC_LO;
                    w_op_nxt        = req_op;
                    w_a_hi_nxt      = req_a[WIDE_W-1:DATA_W];
                    w_b_hi_nxt      = req_b[WIDE_W-1:DATA_W];
                    w_alu_ai_nxt    = req_a[DATA_W-1:0];
                    w_alu_bi_nxt    = w_invert_b ? ~req_b[DATA_W-1:0] : req_b[DATA_W-1:0];
                    case (req_op)
                        OP_AND:  begin w_alu_control_nxt = ALU_AND; w_alu_cin_nxt = 1'b0; end
                        OP_OR:   begin w_alu_control_nxt = ALU_OR;  w_alu_cin_nxt = 1'b0; end
                        OP_XOR:  begin w_alu_control_nxt = ALU_XOR; w_alu_cin_nxt = 1'b0; end
                        OP_SR:   begin w_alu_control_nxt = ALU_SR;  w_alu_cin_nxt = req_carry_in; end
                        OP_CMP:  begin w_alu_control_nxt = ALU_ADD; w_alu_cin_nxt = 1'b1; end
                        default: begin w_alu_control_nxt = ALU_ADD; w_alu_cin_nxt = req_carry_in; end
                    endcase
                end
            end
            S_EXEC_LO: begin
                w_res_lo_nxt = alu_Y;
                if (r_op == OP_ADD16) begin
                    w_state_nxt       = S_EXEC_HI;
                    w_alu_control_nxt = ALU_ADD;
                    w_alu_ai_nxt      = r_a_hi;
                    w_alu_bi_nxt      = r_b_hi;
                    w_alu_cin_nxt     = alu_carry_out;
                end else begin
                    w_state_nxt      = S_RESP;
                    w_rsp_result_nxt = (r_op == OP_CMP) ? '0 : {DATA_W'(0), alu_Y};
                    w_rsp_flags_nxt  = {alu_Y[DATA_W-1], w_y_zero, alu_carry_out, alu_overflow};
                    case (r_op)
                        OP_ADD8, OP_SUB8:      w_rsp_mask_nxt = 4'b1111;
                        OP_CMP, OP_SR:         w_rsp_mask_nxt = 4'b1110;
                        OP_AND, OP_OR, OP_XOR: w_rsp_mask_nxt = 4'b1100;
                        default:               w_rsp_mask_nxt = 4'b0010;
                    endcase
                end
            end
            S_EXEC_HI: begin
                w_state_nxt      = S_RESP;
                w_rsp_result_nxt = {alu_Y, r_res_lo};
                w_rsp_flags_nxt  = {alu_Y[DATA_W-1], w_y_zero && (r_res_lo == '0),
                                    alu_carry_out, alu_overflow};
                w_rsp_mask_nxt   = 4'b0010;
            end
            S_RESP: begin
                // First RESP cycle raises valid; result registers were loaded on the final pass.
                if (!r_rsp_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                end else if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;
    assign rsp_flag_mask = r_rsp_mask;
    assign alu_control   = r_alu_control;
    assign alu_AI        = r_alu_ai;
    assign alu_BI        = r_alu_bi;
    assign alu_carry_in  = r_alu_cin;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU model on the ALU ports.
module tb_alu_op_sequencer;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_SR  = 3'd4;

    localparam logic [2:0] OP_ADD8  = 3'd0;
    localparam logic [2:0] OP_SUB8  = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SR    = 3'd5;
    localparam logic [2:0] OP_ADD16 = 3'd6;
    localparam logic [2:0] OP_CMP   = 3'd7;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_carry_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_flag_mask;
    logic [2:0]  alu_control;
    logic [7:0]  alu_AI;
    logic [7:0]  alu_BI;
    logic        alu_carry_in;
    logic [7:0]  alu_Y;
    logic        alu_carry_out;
    logic        alu_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W(8), .IDLE_ZERO(1'b1),
        .ALU_ADD(ALU_ADD), .ALU_OR(ALU_OR), .ALU_XOR(ALU_XOR), .ALU_AND(ALU_AND), .ALU_SR(ALU_SR)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_carry_in(req_carry_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_flag_mask(rsp_flag_mask),
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_carry_in(alu_carry_in),
        .alu_Y(alu_Y), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
    );

    // Behavioural ALU
    always_comb begin
        logic [8:0] sum;
        sum           = 9'(alu_AI) + 9'(alu_BI) + 9'(alu_carry_in);
        alu_Y         = 8'h00;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                alu_Y         = sum[7:0];
                alu_carry_out = sum[8];
                alu_overflow  = (alu_AI[7] == alu_BI[7]) && (sum[7] != alu_AI[7]);
            end
            ALU_OR:  alu_Y = alu_AI | alu_BI;
            ALU_XOR: alu_Y = alu_AI ^ alu_BI;
            ALU_AND: alu_Y = alu_AI & alu_BI;
            ALU_SR: begin
                alu_Y         = {alu_carry_in, alu_AI[7:1]};
                alu_carry_out = alu_AI[0];
            end
            default: alu_Y = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_op       = op;
        req_a        = a;
        req_b        = b;
        req_carry_in = cin;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int start, input int exp_lat);
        int lat;
        lat = start;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] res, input logic [3:0] flags,
                             input logic [3:0] mask);
        chk({tag, "_result"}, 32'(rsp_result), 32'(res));
        chk({tag, "_flags"}, 32'(rsp_flags), 32'(flags));
        chk({tag, "_mask"}, 32'(rsp_flag_mask), 32'(mask));
    endtask

    task automatic ack(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_a        = 16'h0;
        req_b        = 16'h0;
        req_carry_in = 1'b0;
        rsp_ready    = 1'b0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_control", 32'(alu_control), 32'(ALU_ADD));
        @(negedge clk);
        resetn = 1'b1;

        // ADD8 with signed overflow
        accept("add8", OP_ADD8, 16'h0050, 16'h0050, 1'b0);
        wait_rsp("add8", 0, 2);
        check_rsp("add8", 16'h00A0, 4'b1001, 4'b1111);
        ack("add8");
        chk("idle_ai_zero", 32'(alu_AI), 32'd0);

        // ADD16: low-pass carry feeds the high pass
        accept("add16", OP_ADD16, 16'h12FF, 16'h0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("add16_hi_cin", 32'(alu_carry_in), 32'd1);
        chk("add16_hi_ai", 32'(alu_AI), 32'h12);
        chk("add16_hi_bi", 32'(alu_BI), 32'h00);
        wait_rsp("add16", 1, 3);
        check_rsp("add16", 16'h1300, 4'b0000, 4'b0010);
        ack("add16");

        // CMP equal and less-than
        accept("cmp_eq", OP_CMP, 16'h0010, 16'h0010, 1'b0);
        wait_rsp("cmp_eq", 0, 2);
        check_rsp("cmp_eq", 16'h0000, 4'b0110, 4'b1110);
        ack("cmp_eq");
        accept("cmp_lt", OP_CMP, 16'h000F, 16'h0010, 1'b1);
        wait_rsp("cmp_lt", 0, 2);
        check_rsp("cmp_lt", 16'h0000, 4'b1000, 4'b1110);
        ack("cmp_lt");

        // SR shifts carry into bit 7
        accept("sr", OP_SR, 16'h0003, 16'h0000, 1'b1);
        wait_rsp("sr", 0, 2);
        check_rsp("sr", 16'h0081, 4'b1010, 4'b1110);
        ack("sr");

        // SUB8 0x50-0x30 with no borrow; high bytes of operands ignored
        accept("sub8", OP_SUB8, 16'hAA50, 16'h5530, 1'b1);
        chk("sub8_bi_inv", 32'(alu_BI), 32'hCF);
        wait_rsp("sub8", 0, 2);
        check_rsp("sub8", 16'h0020, 4'b0010, 4'b1111);
        ack("sub8");

        // Back-pressure: response held, second request waits
        accept("and", OP_AND, 16'h00F0, 16'h003C, 1'b0);
        wait_rsp("and", 0, 2);
        req_valid    = 1'b1;
        req_op       = OP_XOR;
        req_a        = 16'h00FF;
        req_b        = 16'h00FF;
        req_carry_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", 32'(rsp_result), 32'h0030);
            chk("hold_flags", 32'(rsp_flags), 32'h0);
            chk("hold_mask", 32'(rsp_flag_mask), 32'hC);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_release_valid", 32'(rsp_valid), 32'd0);
        chk("hold_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("xor_accepted", 32'(req_ready), 32'd0);
        wait_rsp("xor", 0, 2);
        check_rsp("xor", 16'h0000, 4'b0100, 4'b1100);
        ack("xor");

        // Async reset mid ADD16 (during EXEC_HI), after a nonzero result
        accept("sub8b", OP_SUB8, 16'h0050, 16'h0030, 1'b1);
        wait_rsp("sub8b", 0, 2);
        ack("sub8b");
        accept("rst16", OP_ADD16, 16'h12FF, 16'h0001, 1'b0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_result", 32'(rsp_result), 32'd0);
        chk("arst_flags", 32'(rsp_flags), 32'd0);
        chk("arst_mask", 32'(rsp_flag_mask), 32'd0);
        chk("arst_ai", 32'(alu_AI), 32'd0);
        chk("arst_bi", 32'(alu_BI), 32'd0);
        chk("arst_cin", 32'(alu_carry_in), 32'd0);
        chk("arst_control", 32'(alu_control), 32'(ALU_ADD));
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arst_dropped", 32'(rsp_valid), 32'd0);

        accept("post_rst", OP_ADD8, 16'h0001, 16'h0002, 1'b1);
        wait_rsp("post_rst", 0, 2);
        check_rsp("post_rst", 16'h0004, 4'b0000, 4'b1111);
        ack("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
